// File: rtl/inst_fetch.sv
// MIPS32 instruction fetch: PC generation, instruction-bus request/ack, IF/ID producer side.
// Build option INST_ALIGN_CHECK_EN: a misaligned PC presents a flagged NOP instead of a bus cycle.
module inst_fetch (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic        flush,
  input  logic [31:0] new_pc,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_address_i,
  output logic [31:0] iwb_adr_o,
  output logic        iwb_stb_o,
  input  logic        iwb_ack_i,
  input  logic [31:0] iwb_dat_i,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        if_misalign_o,
  output logic        stallreq_from_if
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] br_tgt_q, br_tgt_d;
  logic        br_pend_q, br_pend_d;
  logic [31:0] adr_q, adr_d;
  logic        stb_q, stb_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_inst_q, if_inst_d;
  logic        misalign_q, misalign_d;
  logic        stallreq_q, stallreq_d;

  logic        branch_vld_s;
  logic        consume_s;
  logic [31:0] next_pc_s;
  logic        unused_stall_s;

  assign unused_stall_s = ^{stall[5:3], stall[0]};

  // Next-state and next-output logic; flush outranks consumption, which outranks the branch latch.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    br_tgt_d   = br_tgt_q;
    br_pend_d  = br_pend_q;
    adr_d      = adr_q;
    stb_d      = stb_q;
    if_pc_d    = if_pc_q;
    if_inst_d  = if_inst_q;
    misalign_d = misalign_q;

    branch_vld_s = branch_flag_i & ~stall[2];
    consume_s    = (state_q == HOLD) & ~stall[1];

    // A branch resolving in the consumption cycle itself beats the one latched earlier.
    if (branch_vld_s) begin
      next_pc_s = branch_target_address_i;
    end else if (br_pend_q) begin
      next_pc_s = br_tgt_q;
    end else begin
      next_pc_s = pc_q + 32'd4;
    end

    if (flush) begin
      pc_d       = new_pc;
      br_pend_d  = 1'b0;
      misalign_d = 1'b0;
      case (state_q)
        WAIT, DRAIN: begin
          if (iwb_ack_i) begin
            state_d = IDLE;
            stb_d   = 1'b0;
          end else begin
            state_d = DRAIN;
            stb_d   = 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          stb_d   = 1'b0;
        end
      endcase
    end else begin
      case (state_q)
        IDLE: begin
`ifdef INST_ALIGN_CHECK_EN
          if (pc_q[1:0] != 2'b00) begin
            state_d    = HOLD;
            if_pc_d    = pc_q;
            if_inst_d  = 32'h0000_0000;
            misalign_d = 1'b1;
          end else begin
            state_d = WAIT;
            stb_d   = 1'b1;
            adr_d   = pc_q;
          end
`else
          state_d = WAIT;
          stb_d   = 1'b1;
          adr_d   = {pc_q[31:2], 2'b00};
`endif
        end
        WAIT: begin
          if (iwb_ack_i) begin
            state_d    = HOLD;
            stb_d      = 1'b0;
            if_inst_d  = iwb_dat_i;
            if_pc_d    = pc_q;
            misalign_d = 1'b0;
          end else begin
            state_d = WAIT;
          end
        end
        HOLD: begin
          if (consume_s) begin
            state_d    = IDLE;
            pc_d       = next_pc_s;
            br_pend_d  = 1'b0;
            misalign_d = 1'b0;
          end else begin
            state_d = HOLD;
          end
        end
        DRAIN: begin
          if (iwb_ack_i) begin
            state_d = IDLE;
            stb_d   = 1'b0;
          end else begin
            state_d = DRAIN;
          end
        end
        default: begin
          state_d = IDLE;
          stb_d   = 1'b0;
        end
      endcase

      if (branch_vld_s && !consume_s) begin
        br_pend_d = 1'b1;
        br_tgt_d  = branch_target_address_i;
      end else begin
        br_tgt_d = br_tgt_q;
      end
    end

    stallreq_d = (state_d != HOLD);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      pc_q       <= 32'h0000_0000;
      br_tgt_q   <= 32'h0000_0000;
      br_pend_q  <= 1'b0;
      adr_q      <= 32'h0000_0000;
      stb_q      <= 1'b0;
      if_pc_q    <= 32'h0000_0000;
      if_inst_q  <= 32'h0000_0000;
      misalign_q <= 1'b0;
      stallreq_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      br_tgt_q   <= br_tgt_d;
      br_pend_q  <= br_pend_d;
      adr_q      <= adr_d;
      stb_q      <= stb_d;
      if_pc_q    <= if_pc_d;
      if_inst_q  <= if_inst_d;
      misalign_q <= misalign_d;
      stallreq_q <= stallreq_d;
    end
  end

  assign iwb_adr_o        = adr_q;
  assign iwb_stb_o        = stb_q;
  assign if_pc            = if_pc_q;
  assign if_inst          = if_inst_q;
  assign if_misalign_o    = misalign_q;
  assign stallreq_from_if = stallreq_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: scoreboard of expected (pc, inst) pairs popped on HOLD entry.
module tb_inst_fetch;

  logic        clk;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        branch_flag_i;
  logic [31:0] branch_target_address_i;
  logic [31:0] iwb_adr_o;
  logic        iwb_stb_o;
  logic        iwb_ack_i;
  logic [31:0] iwb_dat_i;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_misalign_o;
  logic        stallreq_from_if;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  exp_t sb_q[$];
  int   total;
  int   bad;

  inst_fetch dut (
    .clk                     (clk),
    .rst                     (rst),
    .stall                   (stall),
    .flush                   (flush),
    .new_pc                  (new_pc),
    .branch_flag_i           (branch_flag_i),
    .branch_target_address_i (branch_target_address_i),
    .iwb_adr_o               (iwb_adr_o),
    .iwb_stb_o               (iwb_stb_o),
    .iwb_ack_i               (iwb_ack_i),
    .iwb_dat_i               (iwb_dat_i),
    .if_pc                   (if_pc),
    .if_inst                 (if_inst),
    .if_misalign_o           (if_misalign_o),
    .stallreq_from_if        (stallreq_from_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h5A5A_0F0F;
  endfunction

  // Bus slave for one request: waits for stb, acks after 'delay' cycles, returns at the HOLD negedge.
  task automatic serve(input int delay, output logic [31:0] adr_seen, output int idle_cycles,
                       output bit stable, output bit got);
    int n;
    n = 0; stable = 1'b1; got = 1'b0; adr_seen = 32'h0;
    @(negedge clk);
    while (iwb_stb_o !== 1'b1 && n < 20) begin
      if (stallreq_from_if !== 1'b1) stable = 1'b0;
      @(negedge clk);
      n++;
    end
    idle_cycles = n;
    if (iwb_stb_o === 1'b1) begin
      got = 1'b1;
      adr_seen = iwb_adr_o;
      for (int k = 0; k < delay; k++) begin
        if (iwb_stb_o !== 1'b1 || iwb_adr_o !== adr_seen || stallreq_from_if !== 1'b1) stable = 1'b0;
        @(negedge clk);
      end
      if (iwb_stb_o !== 1'b1 || iwb_adr_o !== adr_seen || stallreq_from_if !== 1'b1) stable = 1'b0;
      iwb_ack_i = 1'b1;
      iwb_dat_i = mem_word(adr_seen);
      @(negedge clk);
      iwb_ack_i = 1'b0;
      iwb_dat_i = 32'h0;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++;
    if (iwb_stb_o !== 1'b0 || iwb_adr_o !== 32'h0) begin
      bad++; $display("FAIL reset_bus: stb=%b adr=%h want 0 0", iwb_stb_o, iwb_adr_o);
    end
    total++;
    if (if_pc !== 32'h0 || if_inst !== 32'h0 || if_misalign_o !== 1'b0) begin
      bad++; $display("FAIL reset_ifid: pc=%h inst=%h mis=%b want 0 0 0", if_pc, if_inst, if_misalign_o);
    end
    total++;
    if (stallreq_from_if !== 1'b1) begin
      bad++; $display("FAIL reset_stallreq: got %b want 1", stallreq_from_if);
    end
  endtask

  task automatic test_sequential();
    exp_t e; logic [31:0] a; int idl; bit st, got;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      e.pc = 32'(i) << 2; e.inst = mem_word(32'(i) << 2);
      sb_q.push_back(e);
      serve(0, a, idl, st, got);
      e = sb_q.pop_front();
      total++;
      if (!got || a !== e.pc) begin
        bad++; $display("FAIL seq_adr[%0d]: got %h want %h", i, a, e.pc);
      end
      total++;
      if (if_pc !== e.pc || if_inst !== e.inst) begin
        bad++; $display("FAIL seq_data[%0d]: got %h/%h want %h/%h", i, if_pc, if_inst, e.pc, e.inst);
      end
      total++;
      if (stallreq_from_if !== 1'b0 || !st) begin
        bad++; $display("FAIL seq_stallreq[%0d]: hold=%b stable=%b want 0 1", i, stallreq_from_if, st);
      end
      total++;
      if (idl !== ((i == 0) ? 0 : 1)) begin
        bad++; $display("FAIL seq_latency[%0d]: idle cycles %0d want %0d", i, idl, (i == 0) ? 0 : 1);
      end
    end
  endtask

  task automatic test_wait_states();
    exp_t e; logic [31:0] a; int idl; bit st, got;
    e.pc = 32'h0C; e.inst = mem_word(32'h0C);
    sb_q.push_back(e);
    serve(3, a, idl, st, got);
    e = sb_q.pop_front();
    total++;
    if (!got || a !== e.pc || !st) begin
      bad++; $display("FAIL wait_stable: adr=%h stable=%b want %h 1", a, st, e.pc);
    end
    total++;
    if (if_pc !== e.pc || if_inst !== e.inst || stallreq_from_if !== 1'b0) begin
      bad++; $display("FAIL wait_data: got %h/%h sr=%b want %h/%h 0", if_pc, if_inst, stallreq_from_if, e.pc, e.inst);
    end
  endtask

  task automatic test_hold_stall();
    exp_t e; logic [31:0] a; int idl; bit st, got, held;
    e.pc = 32'h10; e.inst = mem_word(32'h10);
    sb_q.push_back(e);
    serve(1, a, idl, st, got);
    e = sb_q.pop_front();
    total++;
    if (!got || if_pc !== e.pc || if_inst !== e.inst) begin
      bad++; $display("FAIL hold_data: got %h/%h want %h/%h", if_pc, if_inst, e.pc, e.inst);
    end
    stall = 6'b000010;
    held = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (if_pc !== e.pc || if_inst !== e.inst || iwb_stb_o !== 1'b0 || stallreq_from_if !== 1'b0) held = 1'b0;
    end
    stall = 6'b000000;
    total++;
    if (!held) begin
      bad++; $display("FAIL hold_stable: outputs changed under stall, got %h/%h stb=%b", if_pc, if_inst, iwb_stb_o);
    end
    for (int i = 0; i < 3; i++) begin
      e.pc = 32'h14 + (32'(i) << 2); e.inst = mem_word(e.pc);
      sb_q.push_back(e);
      serve(0, a, idl, st, got);
      e = sb_q.pop_front();
      total++;
      if (!got || a !== e.pc || if_inst !== e.inst) begin
        bad++; $display("FAIL hold_next[%0d]: adr=%h inst=%h want %h %h", i, a, if_inst, e.pc, e.inst);
      end
    end
  endtask

  task automatic test_branch();
    exp_t e; logic [31:0] a; int idl; bit st, got;
    @(negedge clk);
    branch_flag_i = 1'b1; branch_target_address_i = 32'h100;
    @(negedge clk);
    branch_flag_i = 1'b0; branch_target_address_i = 32'hDEAD_BEEC;
    for (int i = 0; i < 3; i++) begin
      case (i)
        0:       e.pc = 32'h20;
        1:       e.pc = 32'h100;
        default: e.pc = 32'h104;
      endcase
      e.inst = mem_word(e.pc);
      sb_q.push_back(e);
      serve(0, a, idl, st, got);
      e = sb_q.pop_front();
      total++;
      if (!got || a !== e.pc || if_pc !== e.pc || if_inst !== e.inst) begin
        bad++; $display("FAIL branch_seq[%0d]: adr=%h pc=%h inst=%h want %h %h", i, a, if_pc, if_inst, e.pc, e.inst);
      end
    end
  endtask

  task automatic test_flush();
    exp_t e; logic [31:0] a; int idl, n; bit st, got;
    n = 0;
    @(negedge clk);
    while (iwb_stb_o !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    total++;
    if (iwb_stb_o !== 1'b1 || iwb_adr_o !== 32'h108) begin
      bad++; $display("FAIL flush_req: stb=%b adr=%h want 1 00000108", iwb_stb_o, iwb_adr_o);
    end
    flush = 1'b1; new_pc = 32'h140;
    @(negedge clk);
    flush = 1'b0; new_pc = 32'h0;
    total++;
    if (iwb_stb_o !== 1'b1 || stallreq_from_if !== 1'b1) begin
      bad++; $display("FAIL flush_drain: stb=%b sr=%b want 1 1", iwb_stb_o, stallreq_from_if);
    end
    @(negedge clk);
    iwb_ack_i = 1'b1; iwb_dat_i = 32'hBAD0_BAD0;
    @(negedge clk);
    iwb_ack_i = 1'b0; iwb_dat_i = 32'h0;
    total++;
    if (iwb_stb_o !== 1'b0 || stallreq_from_if !== 1'b1 || if_pc !== 32'h104 || if_inst !== mem_word(32'h104)) begin
      bad++; $display("FAIL flush_discard: stb=%b sr=%b pc=%h inst=%h", iwb_stb_o, stallreq_from_if, if_pc, if_inst);
    end
    e.pc = 32'h140; e.inst = mem_word(32'h140);
    sb_q.push_back(e);
    serve(0, a, idl, st, got);
    e = sb_q.pop_front();
    total++;
    if (!got || a !== e.pc || if_pc !== e.pc || if_inst !== e.inst) begin
      bad++; $display("FAIL flush_newpc: adr=%h pc=%h inst=%h want %h %h", a, if_pc, if_inst, e.pc, e.inst);
    end
  endtask

  task automatic test_flush_ack();
    exp_t e; logic [31:0] a; int idl, n; bit st, got;
    n = 0;
    @(negedge clk);
    while (iwb_stb_o !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    total++;
    if (iwb_stb_o !== 1'b1 || iwb_adr_o !== 32'h144) begin
      bad++; $display("FAIL flushack_req: stb=%b adr=%h want 1 00000144", iwb_stb_o, iwb_adr_o);
    end
    iwb_ack_i = 1'b1; iwb_dat_i = 32'hBAD1_BAD1;
    flush = 1'b1; new_pc = 32'h140;
    @(negedge clk);
    iwb_ack_i = 1'b0; iwb_dat_i = 32'h0;
    flush = 1'b0; new_pc = 32'h0;
    total++;
    if (iwb_stb_o !== 1'b0 || stallreq_from_if !== 1'b1 || if_inst !== mem_word(32'h140)) begin
      bad++; $display("FAIL flushack_discard: stb=%b sr=%b inst=%h", iwb_stb_o, stallreq_from_if, if_inst);
    end
    e.pc = 32'h140; e.inst = mem_word(32'h140);
    sb_q.push_back(e);
    serve(0, a, idl, st, got);
    e = sb_q.pop_front();
    total++;
    if (!got || a !== e.pc || idl !== 0 || if_inst !== e.inst) begin
      bad++; $display("FAIL flushack_newpc: adr=%h idle=%0d inst=%h want %h 0 %h", a, idl, if_inst, e.pc, e.inst);
    end
  endtask

  task automatic test_misalign();
    exp_t e; logic [31:0] a; int idl, n; bit st, got, saw_stb;
    branch_flag_i = 1'b1; branch_target_address_i = 32'h102;
    @(negedge clk);
    branch_flag_i = 1'b0; branch_target_address_i = 32'h0;
`ifdef INST_ALIGN_CHECK_EN
    n = 0; saw_stb = 1'b0;
    while (stallreq_from_if !== 1'b0 && n < 5) begin
      @(negedge clk); n++;
      if (iwb_stb_o !== 1'b0) saw_stb = 1'b1;
    end
    total++;
    if (saw_stb || stallreq_from_if !== 1'b0) begin
      bad++; $display("FAIL mis_nobus: saw_stb=%b sr=%b want 0 0", saw_stb, stallreq_from_if);
    end
    total++;
    if (if_inst !== 32'h0 || if_misalign_o !== 1'b1 || if_pc !== 32'h102) begin
      bad++; $display("FAIL mis_nop: inst=%h mis=%b pc=%h want 0 1 00000102", if_inst, if_misalign_o, if_pc);
    end
    @(negedge clk);
    total++;
    if (if_misalign_o !== 1'b0) begin
      bad++; $display("FAIL mis_clear: got %b want 0", if_misalign_o);
    end
    flush = 1'b1; new_pc = 32'h200;
    @(negedge clk);
    flush = 1'b0; new_pc = 32'h0;
    idl = 0; a = 32'h0; st = 1'b0; got = 1'b0; e = '0;
`else
    n = 0; saw_stb = 1'b0;
    e.pc = 32'h102; e.inst = mem_word(32'h100);
    sb_q.push_back(e);
    serve(0, a, idl, st, got);
    e = sb_q.pop_front();
    total++;
    if (!got || a !== 32'h100) begin
      bad++; $display("FAIL mis_adr: got %h want 00000100", a);
    end
    total++;
    if (if_pc !== e.pc || if_inst !== e.inst || if_misalign_o !== 1'b0) begin
      bad++; $display("FAIL mis_data: pc=%h inst=%h mis=%b want %h %h 0", if_pc, if_inst, if_misalign_o, e.pc, e.inst);
    end
`endif
  endtask

  task automatic test_reset_midbus();
    exp_t e; logic [31:0] a; int idl, n; bit st, got;
    n = 0;
    @(negedge clk);
    while (iwb_stb_o !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    total++;
    if (iwb_stb_o !== 1'b1) begin
      bad++; $display("FAIL midrst_req: stb=%b want 1", iwb_stb_o);
    end
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (iwb_stb_o !== 1'b0 || iwb_adr_o !== 32'h0 || stallreq_from_if !== 1'b1 || if_pc !== 32'h0 || if_inst !== 32'h0) begin
      bad++; $display("FAIL midrst_state: stb=%b adr=%h sr=%b pc=%h inst=%h", iwb_stb_o, iwb_adr_o, stallreq_from_if, if_pc, if_inst);
    end
    rst = 1'b0;
    e.pc = 32'h0; e.inst = mem_word(32'h0);
    sb_q.push_back(e);
    serve(0, a, idl, st, got);
    e = sb_q.pop_front();
    total++;
    if (!got || a !== e.pc || idl !== 0 || if_inst !== e.inst) begin
      bad++; $display("FAIL midrst_restart: adr=%h idle=%0d inst=%h want %h 0 %h", a, idl, if_inst, e.pc, e.inst);
    end
  endtask

  initial begin
    rst = 1'b1; stall = 6'b000000; flush = 1'b0; new_pc = 32'h0;
    branch_flag_i = 1'b0; branch_target_address_i = 32'h0;
    iwb_ack_i = 1'b0; iwb_dat_i = 32'h0;
    total = 0; bad = 0;
    test_reset();
    test_sequential();
    test_wait_states();
    test_hold_stall();
    test_branch();
    test_flush();
    test_flush_ack();
    test_misalign();
    test_reset_midbus();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch unit for the five-stage MIPS32 pipeline: generates the PC, runs a request/acknowledge cycle on the instruction bus, and presents the fetched `if_pc`/`if_inst` pair to the IF/ID pipeline register. It drives the producer side of the IF/ID interface. While no instruction is ready it requests a pipeline stall from `ctrl`. It honours `stall`, exception `flush`/`new_pc`, and delayed branches resolved in ID.

## Interface
- No parameters. Reset PC is fixed at 32'h0000_0000; bus widths are 32 bits.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `stall` in 6: pipeline stall vector from `ctrl`. Bit 1 = IF/ID not accepting; bit 2 = ID not advancing; 1 = stop.
- `flush` in 1: exception flush.
- `new_pc` in 32: exception handler address, valid with `flush`.
- `branch_flag_i` in 1: branch taken, from ID.
- `branch_target_address_i` in 32: branch target, from ID.
- `iwb_adr_o` out 32: instruction bus address.
- `iwb_stb_o` out 1: instruction bus request.
- `iwb_ack_i` in 1: bus acknowledge, one cycle per request.
- `iwb_dat_i` in 32: read data, valid with `iwb_ack_i`.
- `if_pc` out 32: PC of the presented instruction, to IF/ID.
- `if_inst` out 32: presented instruction, to IF/ID.
- `if_misalign_o` out 1: presented instruction came from a misaligned PC.
- `stallreq_from_if` out 1: fetch not ready; request stall to `ctrl`.

## Operation
- State machine states: IDLE, WAIT, HOLD, DRAIN.
- Internal registers: `pc`, `br_pend`, `br_tgt`, instruction buffer.
- IDLE:
  - Next cycle: `iwb_stb_o` = 1, `iwb_adr_o` = `pc`, go to WAIT.
  - `iwb_stb_o` is 0 in IDLE.
- WAIT:
  - `iwb_stb_o` held at 1 and `iwb_adr_o` held stable until `iwb_ack_i`.
  - On `iwb_ack_i`: capture `iwb_dat_i` into `if_inst`, `pc` into `if_pc`, drop `iwb_stb_o`, go to HOLD.
- HOLD: instruction is presented.
  - When `stall[1]` = 0 (IF/ID samples at this edge), the instruction is consumed.
  - On consumption, `pc` <= branch target if branch selected, else `pc`+4; go to IDLE.
  - While `stall[1]` = 1, remain in HOLD with outputs stable.
- `stallreq_from_if` = 1 in IDLE, WAIT and DRAIN; 0 in HOLD.
- Delayed branch:
  - When `branch_flag_i` = 1 and `stall[2]` = 0, set `br_pend` <= 1 and `br_tgt` <= `branch_target_address_i`.
  - On the next consumption (the delay slot), the branch target is selected. The live `branch_flag_i` in the same cycle takes priority over `br_pend`.
  - `br_pend` clears on consumption.
- Flush, highest priority after reset:
  - `pc` <= `new_pc`; `br_pend` cleared.
  - From HOLD or IDLE: go to IDLE.
  - From WAIT: go to DRAIN with `iwb_stb_o` kept at 1. On `iwb_ack_i`, discard the data and go to IDLE.
  - A flush in DRAIN updates `pc` again and stays in DRAIN.
- Priority order: `rst` > `flush` > consumption > branch latch.

## Timing
- Reset values:
  - state IDLE, `pc` = 0, `br_pend` = 0.
  - `iwb_stb_o` = 0, `iwb_adr_o` = 0.
  - `if_pc` = 0, `if_inst` = 0, `if_misalign_o` = 0, `stallreq_from_if` = 1.
- Latency:
  - A zero-wait-state bus (ack in the first stb cycle) presents an instruction 2 cycles after IDLE entry.
  - Throughput with no stalls is 3 cycles per instruction (IDLE, WAIT, HOLD).
- Reset asserted mid-bus-cycle drops `iwb_stb_o` at the next edge; the slave must tolerate this.
- `if_pc`/`if_inst` change only on entry to HOLD; they are never altered while in HOLD.
- Simultaneous `flush` and `iwb_ack_i` in WAIT: data discarded, go straight to IDLE at `new_pc`.
- `pc`+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 0).

## Configuration
- `INST_ALIGN_CHECK_EN` defined:
  - In IDLE, if `pc[1:0]` != 0, no bus cycle is issued.
  - Go to HOLD with `if_inst` = 0 (NOP), `if_pc` = `pc`, `if_misalign_o` = 1. `if_misalign_o` clears when the instruction is consumed.
  - On consumption, the next PC follows the normal rules.
- `INST_ALIGN_CHECK_EN` undefined:
  - `iwb_adr_o[1:0]` forced to 00.
  - `if_misalign_o` tied to 0.

## Test plan
- Reset release, ack in same cycle as stb, `stall` = 0:
  - `iwb_adr_o` sequence 0, 4, 8.
  - `if_inst` matches `iwb_dat_i`.
  - `stallreq_from_if` low exactly one cycle per instruction.
- Ack delayed 3 cycles:
  - `iwb_stb_o`/`iwb_adr_o` stable for 4 cycles.
  - `stallreq_from_if` = 1 throughout, 0 on entry to HOLD.
- Hold `stall[1]` = 1 for 5 cycles in HOLD:
  - `if_pc`/`if_inst` unchanged, no new bus request.
  - After release, next address = PC+4.
- `branch_flag_i` = 1, target 32'h100, while fetching the delay slot at 32'h20:
  - Delay slot 32'h20 presented.
  - Next `iwb_adr_o` = 32'h100.
- `flush` with `new_pc` = 32'h140 in WAIT, ack 2 cycles later:
  - Ack data not presented.
  - Next `iwb_adr_o` = 32'h140.
  - Also: flush coincident with ack -> next request at 32'h140.
- With `INST_ALIGN_CHECK_EN`, branch to 32'h102:
  - No bus request.
  - `if_inst` = 0, `if_misalign_o` = 1, `if_pc` = 32'h102.
